// File: rtl/mem_responder.sv
// Memory responder: captures a single rd/wr request, services it from a word array after
// WAIT_STATES cycles, and pulses ready once per request level; simultaneous rd+wr flags err.
module mem_responder #(
  parameter int AWIDTH      = 5,
  parameter int DWIDTH      = 8,
  parameter int WAIT_STATES = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              mem_rd,
  input  logic              mem_wr,
  input  logic [AWIDTH-1:0] addr,
  input  logic [DWIDTH-1:0] wr_data,
  output logic [DWIDTH-1:0] rd_data,
  output logic              ready,
  output logic              busy,
  output logic              err
);

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_ACK, S_HOLD} state_t;

  state_t              r_state;
  state_t              w_next;
  logic [3:0]          r_cnt;
  logic [3:0]          w_cnt_nxt;
  logic                r_op_wr;
  logic [AWIDTH-1:0]   r_addr;
  logic [DWIDTH-1:0]   r_wdat;
  logic [DWIDTH-1:0]   r_rd_data;
  logic                r_ready;
  logic                r_err;
  logic                w_capture;
  logic                w_access;
  logic                w_err_nxt;
  logic                w_acc_wr;
  logic [AWIDTH-1:0]   w_acc_addr;
  logic [DWIDTH-1:0]   w_acc_dat;
  logic [DWIDTH-1:0]   r_mem [2**AWIDTH];

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_IDLE;
      r_cnt   <= 4'd0;
    end else begin
      r_state <= w_next;
      r_cnt   <= w_cnt_nxt;
    end
  end

  // With zero wait states the access happens at the capture edge, so it must use the live inputs.
  always_comb begin
    w_next     = r_state;
    w_cnt_nxt  = r_cnt;
    w_capture  = 1'b0;
    w_access   = 1'b0;
    w_err_nxt  = 1'b0;
    w_acc_wr   = r_op_wr;
    w_acc_addr = r_addr;
    w_acc_dat  = r_wdat;
    case (r_state)
      S_IDLE: begin
        if (mem_rd ^ mem_wr) begin
          w_capture  = 1'b1;
          w_acc_wr   = mem_wr;
          w_acc_addr = addr;
          w_acc_dat  = wr_data;
          if (WAIT_STATES == 0) begin
            w_access = 1'b1;
            w_next   = S_ACK;
          end else begin
            w_cnt_nxt = 4'(WAIT_STATES);
            w_next    = S_WAIT;
          end
        end else if (mem_rd && mem_wr) begin
          w_err_nxt = 1'b1;
        end
      end
      S_WAIT: begin
        w_cnt_nxt = r_cnt - 4'd1;
        if (r_cnt == 4'd1) begin
          w_access = 1'b1;
          w_next   = S_ACK;
        end
      end
      S_ACK: begin
        w_next = (mem_rd || mem_wr) ? S_HOLD : S_IDLE;
      end
      S_HOLD: begin
        if (!mem_rd && !mem_wr) w_next = S_IDLE;
      end
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_op_wr   <= 1'b0;
      r_addr    <= '0;
      r_wdat    <= '0;
      r_rd_data <= '0;
      r_ready   <= 1'b0;
      r_err     <= 1'b0;
    end else begin
      r_ready <= w_access;
      r_err   <= w_err_nxt;
      if (w_capture) begin
        r_op_wr <= mem_wr;
        r_addr  <= addr;
        r_wdat  <= wr_data;
      end
      if (w_access && !w_acc_wr) r_rd_data <= r_mem[w_acc_addr];
    end
  end

  // Array is not reset; rst still suppresses a write that would land on the reset edge.
  always_ff @(posedge clk) begin
    if (!rst && w_access && w_acc_wr) r_mem[w_acc_addr] <= w_acc_dat;
  end

  assign rd_data = r_rd_data;
  assign ready   = r_ready;
  assign err     = r_err;
  assign busy    = (r_state != S_IDLE);

endmodule

// File: tb/tb_mem_responder.sv
// Directed bench for mem_responder (WAIT_STATES=2): timing of ready/busy/err, hold, abort.
module tb_mem_responder;

  logic       clk = 1'b0;
  logic       rst;
  logic       mem_rd;
  logic       mem_wr;
  logic [4:0] addr;
  logic [7:0] wr_data;
  logic [7:0] rd_data;
  logic       ready;
  logic       busy;
  logic       err;

  int n_chk  = 0;
  int n_pass = 0;

  mem_responder #(.AWIDTH(5), .DWIDTH(8), .WAIT_STATES(2)) dut (
    .clk(clk), .rst(rst), .mem_rd(mem_rd), .mem_wr(mem_wr), .addr(addr),
    .wr_data(wr_data), .rd_data(rd_data), .ready(ready), .busy(busy), .err(err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
  endtask

  // Advance one edge and settle; outputs are then those updated by that edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_write(input logic [4:0] a, input logic [7:0] d);
    addr = a; wr_data = d; mem_wr = 1'b1;
    step();
    chk("wr_busy_k", busy, 1);
    chk("wr_rdy_k", ready, 0);
    mem_wr = 1'b0;
    step();
    chk("wr_rdy_k1", ready, 0);
    step();
    chk("wr_rdy_k2", ready, 1);
    step();
    chk("wr_rdy_k3", ready, 0);
    chk("wr_busy_k3", busy, 0);
  endtask

  task automatic do_read(input logic [4:0] a, input logic [7:0] exp);
    addr = a; mem_rd = 1'b1;
    step();
    chk("rd_busy_k", busy, 1);
    mem_rd = 1'b0;
    step();
    chk("rd_rdy_k1", ready, 0);
    step();
    chk("rd_rdy_k2", ready, 1);
    chk("rd_data", rd_data, exp);
    step();
    chk("rd_busy_k3", busy, 0);
  endtask

  initial begin
    int pulses;
    rst = 1'b1; mem_rd = 1'b1; mem_wr = 1'b0; addr = '0; wr_data = '0;
    // 1: reset with a read request pending
    repeat (2) begin
      step();
      chk("rst_ready", ready, 0);
      chk("rst_busy", busy, 0);
      chk("rst_err", err, 0);
      chk("rst_rd_data", rd_data, 8'h00);
    end
    rst = 1'b0; mem_rd = 1'b0;
    step();
    chk("post_rst_busy", busy, 0);

    // 2: write 5 <= A5
    do_write(5'd5, 8'hA5);

    // 3: read back, then rd_data holds while idle
    do_read(5'd5, 8'hA5);
    for (int i = 0; i < 10; i++) begin
      step();
      chk("rd_hold", rd_data, 8'hA5);
    end

    // 4: held level gives one access; re-arm after deassert
    addr = 5'd5; mem_rd = 1'b1; pulses = 0;
    for (int i = 0; i < 8; i++) begin
      step();
      if (ready) pulses++;
      chk("hold_busy", busy, 1);
    end
    chk("hold_pulses", pulses, 1);
    mem_rd = 1'b0;
    step();
    chk("hold_release_busy", busy, 0);
    mem_rd = 1'b1;
    step();
    chk("rearm_busy", busy, 1);
    step();
    chk("rearm_rdy_k1", ready, 0);
    step();
    chk("rearm_rdy_k2", ready, 1);
    chk("rearm_data", rd_data, 8'hA5);
    mem_rd = 1'b0;
    step();
    step();
    chk("rearm_idle", busy, 0);

    // 5: simultaneous rd+wr is an error, no access
    addr = 5'd5; wr_data = 8'h11; mem_rd = 1'b1; mem_wr = 1'b1;
    repeat (3) begin
      step();
      chk("both_err", err, 1);
      chk("both_ready", ready, 0);
      chk("both_busy", busy, 0);
    end
    mem_rd = 1'b0; mem_wr = 1'b0;
    step();
    chk("both_err_clr", err, 0);
    do_read(5'd5, 8'hA5);

    // 6: reset during WAIT aborts the write
    do_write(5'd3, 8'h3C);
    addr = 5'd3; wr_data = 8'hFF; mem_wr = 1'b1;
    step();
    chk("abort_busy_k", busy, 1);
    mem_wr = 1'b0;
    step();
    rst = 1'b1;
    step();
    chk("abort_ready", ready, 0);
    chk("abort_busy", busy, 0);
    rst = 1'b0;
    pulses = 0;
    repeat (3) begin
      step();
      if (ready) pulses++;
    end
    chk("abort_no_pulse", pulses, 0);
    do_read(5'd3, 8'h3C);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
